// File: rtl/zbt_bank_arbiter.sv
// zbt_bank_arbiter: two-client round-robin arbiter and access sequencer for
// one ZBT SRAM bank. One memory operation is issued per clock with no
// turnaround bubbles. Write data is delayed to line up with the ZBT pipelined
// write slot, and each read word is steered back to the client that asked.
//
// Handshake: a client raises cN_req together with cN_we/cN_addr/cN_wdata and
// holds all of them stable until cN_gnt is high. gnt is combinational, and the
// request is consumed in the cycle where req && gnt. The client may present a
// new request in the very next cycle. There is no backpressure on read
// returns, so cN_rvalid is a single-cycle pulse the client must accept.
module zbt_bank_arbiter #(
  parameter int ADDR_WIDTH       = 19,
  parameter int DATA_WIDTH       = 32,
  parameter int READ_LATENCY     = 3,
  parameter int WRITE_DATA_DELAY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  c0_req,
  input  logic                  c1_req,
  input  logic                  c0_we,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c0_gnt,
  output logic                  c1_gnt,
  output logic                  c0_rvalid,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  data_direction,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data
);

  // last_grant: 0 = client 0 was served last, 1 = client 1 was served last
  logic                  last_grant;
  logic                  any_gnt;
  logic                  sel_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // wd_pipe[0] is the issue slot; the word leaves WRITE_DATA_DELAY cycles later
  logic [DATA_WIDTH-1:0] wd_pipe   [0:WRITE_DATA_DELAY];
  // Read tags travel alongside the bank latency; stage READ_LATENCY lines up
  // with the cycle where read_data is valid at our input
  logic                  tag_valid [0:READ_LATENCY];
  logic                  tag_id    [0:READ_LATENCY];

  // Round-robin grant: a lone requester wins, a tie goes to the client not served last
  always_comb begin
    c0_gnt = 1'b0;
    c1_gnt = 1'b0;
    if (!reset) begin
      if (c0_req && (!c1_req || last_grant)) begin
        c0_gnt = 1'b1;
      end else if (c1_req) begin
        c1_gnt = 1'b1;
      end
    end
  end

  // Select the granted client's request fields
  always_comb begin
    any_gnt   = c0_gnt | c1_gnt;
    sel_id    = c1_gnt;
    sel_we    = c1_gnt ? c1_we    : c0_we;
    sel_addr  = c1_gnt ? c1_addr  : c0_addr;
    sel_wdata = c1_gnt ? c1_wdata : c0_wdata;
  end

  // Remember who was served last; reset favours client 0 on the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (any_gnt) begin
      last_grant <= sel_id;
    end
  end

  // Issue register: idle cycles become dummy reads at the held address
  always_ff @(posedge clock) begin
    if (reset) begin
      address        <= '0;
      data_direction <= 1'b1;
    end else if (any_gnt) begin
      address        <= sel_addr;
      data_direction <= ~sel_we;
    end else begin
      data_direction <= 1'b1;
    end
  end

  // Write-data delay line; non-write slots carry zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= WRITE_DATA_DELAY; i++) wd_pipe[i] <= '0;
    end else begin
      wd_pipe[0] <= (any_gnt && sel_we) ? sel_wdata : '0;
      for (int i = 1; i <= WRITE_DATA_DELAY; i++) wd_pipe[i] <= wd_pipe[i-1];
    end
  end

  assign write_data = wd_pipe[WRITE_DATA_DELAY];

  // Read tag pipeline; only granted reads carry a valid tag
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_id[i]    <= 1'b0;
      end
    end else begin
      tag_valid[0] <= any_gnt && !sel_we;
      tag_id[0]    <= sel_id;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Return path: capture read_data for the tagged client, rdata holds otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c0_rdata  <= '0;
      c1_rdata  <= '0;
    end else begin
      c0_rvalid <= tag_valid[READ_LATENCY] && !tag_id[READ_LATENCY];
      c1_rvalid <= tag_valid[READ_LATENCY] &&  tag_id[READ_LATENCY];
      if (tag_valid[READ_LATENCY] && !tag_id[READ_LATENCY]) c0_rdata <= read_data;
      if (tag_valid[READ_LATENCY] &&  tag_id[READ_LATENCY]) c1_rdata <= read_data;
    end
  end

endmodule
